// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the ID/EX stage register: decode payload layout,
// the bubble constant and the stage occupancy encoding.
package pipe_stage_skid_pkg;

  typedef logic [31:0] Word_t;
  typedef logic [4:0]  Reg_addr_t;
  typedef logic        Bit_t;

  typedef enum logic [7:0] {
    OP_NOP = 8'h00,
    OP_ORI = 8'h0D,
    OP_AND = 8'h24,
    OP_OR  = 8'h25
  } Oper_t;

  localparam Word_t     ZERO_WORD = 32'h0000_0000;
  localparam Bit_t      DISABLE   = 1'b0;
  localparam Bit_t      ENABLE    = 1'b1;
  localparam Reg_addr_t REG_ZERO  = 5'd0;

  typedef struct packed {
    Oper_t     oper;
    Word_t     reg1;
    Word_t     reg2;
    Bit_t      wreg_write;
    Reg_addr_t wreg_addr;
  } IdEx_t;

  // ori $0, $0, 0 with write-back disabled: a harmless NOP for execute
  localparam IdEx_t ID_EX_BUBBLE = '{OP_ORI, ZERO_WORD, ZERO_WORD, DISABLE, REG_ZERO};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } Stage_state_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream valid-ready handshake of one pipeline stage.
// master = the surrounding pipeline, slave = the stage register itself.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; holds at all-ones.
module pipe_stage_skid_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Count enabled cycles, stop at the maximum value, clear has priority
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// ID/EX stage register with 2-entry skid buffer, flush and stall counter.
//
//   state | meaning
//   EMPTY | no beat held, out_data = BUBBLE, in_ready = 1
//   FULL  | main entry valid, in_ready = 1
//   SKID  | main and skid entries valid, in_ready = 0
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int              DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter int              CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_skid_if.slave  bus,
  output logic [CNT_W-1:0]  stall_cnt
);

  Stage_state_t      state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              main_en, main_from_skid, skid_en;
  logic              accept, pop;

  // Handshake outputs come from the state register only
  assign bus.in_ready  = (state_q != SKID);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = (state_q != EMPTY) ? main_q : BUBBLE;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;

  // Next-state and payload load enables; flush kills everything held
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          main_en = 1'b1;
        end
      end
      FULL: begin
        if (accept && pop) begin
          main_en = 1'b1;
        end else if (accept) begin
          state_d = SKID;
          skid_en = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      SKID: begin
        if (pop) begin
          state_d        = FULL;
          main_en        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload entries load only when enabled; validity lives in state_q
  always_ff @(posedge clk) begin
    if (main_en) begin
      main_q <= main_from_skid ? skid_q : bus.in_data;
    end
    if (skid_en) begin
      skid_q <= bus.in_data;
    end
  end

  pipe_stage_skid_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (bus.out_valid & ~bus.out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed vector table plus stall saturation and randomised FIFO-order checks.
module tb_pipe_stage_skid;

  localparam int          DW  = 8;
  localparam int          CW  = 4;
  localparam logic [7:0]  BUB = 8'hEE;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [CW-1:0] stall_cnt;

  pipe_stage_skid_if #(.DATA_W(DW)) bus ();

  pipe_stage_skid #(.DATA_W(DW), .BUBBLE(BUB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, flush, iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir, e_ov;
    logic [7:0] e_od;
    logic [3:0] e_sc;
  } vec_t;

  vec_t vq[$];
  int   total  = 0;
  int   passed = 0;

  task automatic add(input logic r, input logic f, input logic iv, input logic [7:0] d,
                     input logic ordy, input logic ir, input logic ov,
                     input logic [7:0] od, input logic [3:0] sc);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_sc = sc;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [7:0] d, input logic ordy);
    rst = r; flush = f; bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic       m_acc, m_pop;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    // rst flush iv  data  ordy | in_ready out_valid out_data stall
    add(1, 0, 1, 8'hA5, 0,  1, 0, BUB,   0);  // reset with in_valid high
    add(0, 0, 1, 8'hA5, 0,  1, 1, 8'hA5, 0);  // first accept, 1-cycle latency
    add(0, 0, 0, 8'h00, 1,  1, 0, BUB,   0);
    add(0, 0, 1, 8'h01, 1,  1, 1, 8'h01, 0);  // streaming 1..4
    add(0, 0, 1, 8'h02, 1,  1, 1, 8'h02, 0);
    add(0, 0, 1, 8'h03, 1,  1, 1, 8'h03, 0);
    add(0, 0, 1, 8'h04, 1,  1, 1, 8'h04, 0);
    add(0, 0, 0, 8'h00, 1,  1, 0, BUB,   0);
    add(0, 0, 1, 8'h01, 0,  1, 1, 8'h01, 0);  // back-pressure: 1 main
    add(0, 0, 1, 8'h02, 0,  0, 1, 8'h01, 1);  // 2 into skid
    add(0, 0, 1, 8'h03, 0,  0, 1, 8'h01, 2);  // 3 held upstream
    add(0, 0, 1, 8'h03, 1,  1, 1, 8'h02, 2);
    add(0, 0, 1, 8'h03, 1,  1, 1, 8'h03, 2);
    add(0, 0, 0, 8'h00, 1,  1, 0, BUB,   2);
    add(0, 0, 1, 8'h07, 0,  1, 1, 8'h07, 2);  // SKID with 7,8
    add(0, 0, 1, 8'h08, 0,  0, 1, 8'h07, 3);
    add(0, 1, 1, 8'h09, 0,  1, 0, BUB,   4);  // flush, 9 discarded
    add(0, 0, 0, 8'h00, 1,  1, 0, BUB,   4);
    add(0, 0, 1, 8'h11, 0,  1, 1, 8'h11, 4);
    add(0, 1, 1, 8'h22, 1,  1, 0, BUB,   4);  // flush with pop and accept
    add(0, 0, 1, 8'h33, 0,  1, 1, 8'h33, 4);
    add(1, 0, 1, 8'h44, 0,  1, 0, BUB,   0);  // reset while FULL
    add(0, 0, 1, 8'h55, 1,  1, 1, 8'h55, 0);
    add(0, 0, 0, 8'h00, 1,  1, 0, BUB,   0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].flush, vq[i].iv, vq[i].d, vq[i].ordy);
      tick();
      chk($sformatf("v%0d in_ready", i),  {31'd0, bus.in_ready},  {31'd0, vq[i].e_ir});
      chk($sformatf("v%0d out_valid", i), {31'd0, bus.out_valid}, {31'd0, vq[i].e_ov});
      chk($sformatf("v%0d out_data", i),  {24'd0, bus.out_data},  {24'd0, vq[i].e_od});
      chk($sformatf("v%0d stall_cnt", i), {28'd0, stall_cnt},     {28'd0, vq[i].e_sc});
    end

    // Stall saturation with payload stability
    drive(0, 0, 1, 8'h66, 0);
    tick();
    for (int k = 1; k <= 20; k++) begin
      drive(0, 0, 0, 8'h00, 0);
      tick();
      chk($sformatf("sat%0d stall_cnt", k), {28'd0, stall_cnt}, (k > 15) ? 32'd15 : k);
      chk($sformatf("sat%0d out_data", k),  {24'd0, bus.out_data}, 32'h66);
    end
    drive(0, 1, 0, 8'h00, 0);
    tick();
    chk("sat flush stall_cnt", {28'd0, stall_cnt}, 32'd15);
    chk("sat flush out_valid", {31'd0, bus.out_valid}, 32'd0);
    drive(0, 0, 0, 8'h00, 1);
    tick();
    chk("sat idle stall_cnt", {28'd0, stall_cnt}, 32'd15);
    drive(1, 0, 0, 8'h00, 1);
    tick();
    chk("sat rst stall_cnt", {28'd0, stall_cnt}, 32'd0);

    // Random traffic against a 2-deep FIFO model
    for (int c = 0; c < 300; c++) begin
      drive(0, 0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
      if (c > 280) bus.out_ready = 1'b1;
      if (c > 280) bus.in_valid  = 1'b0;
      #1;
      chk("rnd in_ready",  {31'd0, bus.in_ready},  {31'd0, q.size() < 2});
      chk("rnd out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) chk("rnd out_data", {24'd0, bus.out_data}, {24'd0, q[0]});
      else              chk("rnd bubble",   {24'd0, bus.out_data}, {24'd0, BUB});
      m_pop = (q.size() > 0) && bus.out_ready;
      m_acc = (q.size() < 2) && bus.in_valid;
      if (m_pop) void'(q.pop_front());
      if (m_acc) q.push_back(bus.in_data);
      tick();
    end
    chk("rnd drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
